switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//  Conditions raw board switch/button inputs (joystick, user DIP switches, selection switches,
//  mikroBUS interrupt) before they reach the sonata_system general-purpose input port.
//  Per bit: synchronise, optionally invert (active-low pull-up switches), debounce against a
//  shared sample tick, then report edges. A sticky change flag serves as a GPIO interrupt source.
//  Sits between the top-level pad inputs and sonata_system gp_i; clocked by clk_sys.
// PARAMETERS
//  Width          16          number of switch bits conditioned
//  SampleCycles   30_000      clk_i cycles per sample tick (1 ms at 30 MHz); legal range >= 1
//  StableSamples  4           consecutive disagreeing ticks required to accept a new level; >= 1
//  InvertMask     '1          bit i = 1: sw_i[i] is active-low and is inverted on entry
//  ResetValue     '0          post-inversion reset level of the sync flops and of sw_o
// PORTS
//  clk_i             in   1      system clock (clk_sys)
//  rst_i             in   1      synchronous, active-high reset
//  sw_i              in   Width  raw asynchronous switch pins
//  sw_o              out  Width  debounced active-high switch state
//  rise_o            out  Width  1-cycle pulse: sw_o[i] went 0->1 this cycle
//  fall_o            out  Width  1-cycle pulse: sw_o[i] went 1->0 this cycle
//  change_pending_o  out  1      sticky: any rise/fall since last clear
//  change_clr_i      in   1      clears change_pending_o
// BEHAVIOUR
//  Clock and reset
//   - One clock (clk_i).
//   - Reset is synchronous and active-high on rst_i.
//   - All flops are cleared on the rising clk_i edge while rst_i = 1.
//  Reset values
//   - sw_o = ResetValue; sync stages = ResetValue.
//   - rise_o = fall_o = 0; change_pending_o = 0.
//   - Prescaler = 0; all per-bit counters = 0.
//   - No pulses are produced in the cycle after reset deasserts.
//  Synchroniser
//   - Two-flop chain per bit on (sw_i ^ InvertMask); sync_q is the second stage.
//  Prescaler
//   - Counter counts 0..SampleCycles-1, then wraps to 0.
//   - tick = (count == SampleCycles-1).
//   - SampleCycles = 1 gives tick every cycle.
//   - Width is $clog2(SampleCycles), minimum 1.
//  Per-bit debounce
//   - cnt[i] width is $clog2(StableSamples+1). Updates only on tick cycles; holds otherwise.
//   - If sync_q[i] == sw_o[i]: cnt[i] <= 0. Any agreeing sample restarts the count (bounce rejection).
//   - Else if cnt[i] + 1 == StableSamples: sw_o[i] <= sync_q[i], cnt[i] <= 0, and the matching
//     rise_o[i] / fall_o[i] is 1 in the same cycle in which sw_o[i] changes.
//   - Else: cnt[i] <= cnt[i] + 1.
//   - Counters never exceed StableSamples - 1, so no wrap-around is possible.
//  Latency
//   - Clean, stable input change -> sw_o change: min 2 + (StableSamples-1)*SampleCycles + 1 cycles,
//     max 2 + StableSamples*SampleCycles cycles.
//  Edge outputs
//   - rise_o and fall_o are registered and are never 1 simultaneously for the same bit.
//   - Multiple bits may pulse in the same cycle.
//  Sticky flag
//   - change_pending_o is set when |(rise|fall) in the current cycle is 1.
//   - If set and change_clr_i coincide, set wins and the flag stays 1.
//   - change_clr_i alone clears the flag on the next edge.
//  Reset mid-operation
//   - Partial counts are discarded.
//   - A new level requires the full StableSamples ticks after reset is released.
// TESTING (bench uses Width=4, SampleCycles=4, StableSamples=3, InvertMask=4'b0010, ResetValue=0)
//  1. Hold rst_i 3 cycles with sw_i=4'b0010 -> sw_o=0, rise_o=fall_o=0, change_pending_o=0 during
//     reset and afterwards.
//  2. Drive sw_i[0] 0->1 and hold -> sw_o[0]=1 within cycles 11..14; rise_o[0]=1 for exactly that one
//     cycle; change_pending_o=1 from the next cycle.
//  3. Toggle sw_i[2] every 5 cycles for 60 cycles, then hold 1 -> no sw_o[2] change during toggling;
//     exactly one rise_o[2] pulse after the hold.
//  4. Drive sw_i[1]=0 (inverted bit) -> sw_o[1]=1 after debounce; then sw_i[1]=1 -> one fall_o[1]
//     pulse and sw_o[1]=0.
//  5. Assert change_clr_i in the same cycle as a rise_o pulse -> change_pending_o stays 1; clr alone
//     on the next cycle -> 0.
//  6. Pulse rst_i after 2 disagreeing ticks on bit 3 -> sw_o[3] stays 0 until 3 full ticks after
//     reset release.

Source files
------------

// File: rtl/switch_debounce.sv
// Per-bit switch conditioner: two-flop synchroniser, optional inversion, tick-based
// debounce with registered rise/fall pulses and a sticky change flag for interrupts.
module switch_debounce #(
  parameter int              Width         = 16,
  parameter int              SampleCycles  = 30000,
  parameter int              StableSamples = 4,
  parameter logic [Width-1:0] InvertMask   = '1,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] sw_i,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             change_pending_o,
  input  logic             change_clr_i
);

  localparam int PsW  = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;
  localparam int CntW = ($clog2(StableSamples + 1) > 0) ? $clog2(StableSamples + 1) : 1;
  localparam logic [PsW-1:0]  PsLast  = PsW'(SampleCycles - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(StableSamples - 1);

  logic [Width-1:0] sync1_r;
  logic [Width-1:0] sync2_r;
  logic [PsW-1:0]   ps_r;
  logic             tick_s;
  logic [Width-1:0] sw_r;
  logic [Width-1:0] sw_nxt_s;
  logic [Width-1:0] rise_r;
  logic [Width-1:0] fall_r;
  logic [Width-1:0] rise_nxt_s;
  logic [Width-1:0] fall_nxt_s;
  logic [CntW-1:0]  cnt_r     [Width];
  logic [CntW-1:0]  cnt_nxt_s [Width];
  logic             pending_r;

  // Two-flop synchroniser on the polarity-corrected pins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r <= ResetValue;
      sync2_r <= ResetValue;
    end else begin
      sync1_r <= sw_i ^ InvertMask;
      sync2_r <= sync1_r;
    end
  end

  // Shared sample-tick prescaler
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_r <= '0;
    end else if (tick_s) begin
      ps_r <= '0;
    end else begin
      ps_r <= ps_r + PsW'(1);
    end
  end

  assign tick_s = (ps_r == PsLast);

  // Debounce next-state: an agreeing sample restarts the run, a full run accepts the level
  always_comb begin
    sw_nxt_s   = sw_r;
    rise_nxt_s = '0;
    fall_nxt_s = '0;
    cnt_nxt_s  = cnt_r;
    if (tick_s) begin
      for (int i = 0; i < Width; i++) begin
        if (sync2_r[i] == sw_r[i]) begin
          cnt_nxt_s[i] = '0;
        end else if (cnt_r[i] == CntLast) begin
          sw_nxt_s[i]   = sync2_r[i];
          rise_nxt_s[i] = sync2_r[i];
          fall_nxt_s[i] = ~sync2_r[i];
          cnt_nxt_s[i]  = '0;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CntW'(1);
        end
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Debounced state, run counters and edge pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_r   <= ResetValue;
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sw_r   <= sw_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
      for (int i = 0; i < Width; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Sticky change flag; a new edge outranks a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r <= 1'b0;
    end else if (|(rise_r | fall_r)) begin
      pending_r <= 1'b1;
    end else if (change_clr_i) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign sw_o             = sw_r;
  assign rise_o           = rise_r;
  assign fall_o           = fall_r;
  assign change_pending_o = pending_r;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: a tick-window reference model predicts levels,
// pulses and the sticky flag; a negedge monitor compares the DUT against it every cycle.
module tb_switch_debounce;

  localparam int         SC  = 4;
  localparam int         SS  = 3;
  localparam logic [3:0] INV = 4'b0010;

  typedef struct packed {
    int         stamp;
    logic [3:0] r;
    logic [3:0] f;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       change_clr;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       pend;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int         n = -1;
  int         r0 = 0;
  logic [3:0] xh [16];
  logic [3:0] ts [4096];
  int         tcount = 0;
  int         anchor [4];
  logic [3:0] m_sw = 4'd0;
  logic [3:0] m_rise = 4'd0;
  logic [3:0] m_fall = 4'd0;
  logic       m_pend = 1'b0;
  bit         model_valid = 1'b0;
  ev_t        evq [$];
  int         rise_cnt [4];
  int         fall_cnt [4];

  switch_debounce #(
    .Width(4), .SampleCycles(SC), .StableSamples(SS), .InvertMask(INV), .ResetValue(4'b0000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sw_i(sw_in), .sw_o(sw_out), .rise_o(rise), .fall_o(fall),
    .change_pending_o(pend), .change_clr_i(change_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // One clock edge: the model applies the rules to the inputs that edge sees.
  task automatic step();
    logic [3:0] x_now;
    logic [3:0] samp;
    logic [3:0] pr;
    logic [3:0] pf;
    logic       rst_now;
    logic       clr_now;
    bit         all_dis;
    int         idx;
    x_now   = sw_in ^ INV;
    rst_now = rst;
    clr_now = change_clr;
    @(posedge clk);
    n++;
    xh[n % 16] = x_now;
    pr = m_rise;
    pf = m_fall;
    if (rst_now) begin
      m_sw = 4'd0; m_rise = 4'd0; m_fall = 4'd0; m_pend = 1'b0;
      r0 = n + 1;
      for (int b = 0; b < 4; b++) anchor[b] = tcount;
      model_valid = 1'b1;
    end else begin
      m_rise = 4'd0;
      m_fall = 4'd0;
      if ((pr | pf) != 4'd0) m_pend = 1'b1;
      else if (clr_now) m_pend = 1'b0;
      if (((n - r0) % SC) == SC - 1) begin
        samp = xh[(n - 2) % 16];
        ts[tcount] = samp;
        for (int b = 0; b < 4; b++) begin
          // accept when the last SS samples since the last anchor all disagree
          all_dis = 1'b1;
          for (int k = 0; k < SS; k++) begin
            idx = tcount - k;
            if (idx < anchor[b]) all_dis = 1'b0;
            else if (ts[idx][b] == m_sw[b]) all_dis = 1'b0;
          end
          if (all_dis) begin
            m_sw[b]   = samp[b];
            m_rise[b] = samp[b];
            m_fall[b] = ~samp[b];
            anchor[b] = tcount + 1;
          end
        end
        tcount++;
      end
      if ((m_rise | m_fall) != 4'd0) evq.push_back('{n, m_rise, m_fall});
    end
    #1;
  endtask

  // Monitor: pops expected pulses and compares levels every cycle
  always @(negedge clk) begin : monitor
    ev_t e;
    if (model_valid) begin
      check("sw_o", {28'd0, sw_out}, {28'd0, m_sw});
      check("change_pending_o", {31'd0, pend}, {31'd0, m_pend});
      check("rise_fall_exclusive", {28'd0, rise & fall}, 32'd0);
      if (evq.size() > 0 && evq[0].stamp == n) begin
        e = evq.pop_front();
        check("edge_pulse", {24'd0, rise, fall}, {24'd0, e.r, e.f});
      end else begin
        check("no_pulse", {24'd0, rise, fall}, 32'd0);
      end
      for (int b = 0; b < 4; b++) begin
        rise_cnt[b] += int'(rise[b]);
        fall_cnt[b] += int'(fall[b]);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n0;
    int  lat;
    bit  found;
    int  base;
    int  ticks;
    int  hold;
    int  bit_idx;
    for (int b = 0; b < 4; b++) begin
      anchor[b] = 0; rise_cnt[b] = 0; fall_cnt[b] = 0;
    end
    rst = 1'b1; sw_in = 4'b0010; change_clr = 1'b0;

    // 1: reset state
    repeat (3) begin
      step();
      check("reset_sw_o", {28'd0, sw_out}, 32'd0);
      check("reset_edges", {24'd0, rise, fall}, 32'd0);
      check("reset_pending", {31'd0, pend}, 32'd0);
    end
    rst = 1'b0;
    step();
    check("post_reset_edges", {24'd0, rise, fall}, 32'd0);
    repeat (3) step();

    // 2: clean rise on bit 0, latency window 11..14
    sw_in[0] = 1'b1; n0 = n; found = 1'b0; lat = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (sw_out[0]) begin found = 1'b1; lat = n - n0; end
    end
    check("t2_sw0_rose", {31'd0, found}, 32'd1);
    check("t2_latency_11_14", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
    check("t2_rise0_now", {28'd0, rise}, 32'd1);
    step();
    check("t2_rise0_single", {28'd0, rise}, 32'd0);
    check("t2_pending", {31'd0, pend}, 32'd1);
    check("t2_rise0_count", rise_cnt[0], 32'd1);

    // 3: bouncing bit 2 never accepted, then one clean rise
    base = rise_cnt[2];
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) sw_in[2] = ~sw_in[2];
      step();
    end
    check("t3_no_change_bounce", {31'd0, sw_out[2]}, 32'd0);
    check("t3_no_rise_bounce", rise_cnt[2], base);
    sw_in[2] = 1'b1;
    repeat (20) step();
    check("t3_one_rise", rise_cnt[2], base + 1);
    check("t3_sw2_high", {31'd0, sw_out[2]}, 32'd1);

    // 4: inverted bit 1
    base = fall_cnt[1];
    sw_in[1] = 1'b0;
    repeat (20) step();
    check("t4_sw1_high", {31'd0, sw_out[1]}, 32'd1);
    sw_in[1] = 1'b1;
    repeat (20) step();
    check("t4_one_fall", fall_cnt[1], base + 1);
    check("t4_sw1_low", {31'd0, sw_out[1]}, 32'd0);

    // 5: set wins over clear, then clear alone
    change_clr = 1'b1; step(); change_clr = 1'b0; step();
    check("t5_cleared", {31'd0, pend}, 32'd0);
    sw_in[1] = 1'b0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (rise[1]) found = 1'b1;
    end
    check("t5_rise1_seen", {31'd0, found}, 32'd1);
    change_clr = 1'b1;
    step();
    check("t5_set_wins", {31'd0, pend}, 32'd1);
    step();
    check("t5_clr_alone", {31'd0, pend}, 32'd0);
    change_clr = 1'b0;

    // 6: reset after two disagreeing ticks discards the partial run
    sw_in[3] = 1'b1;
    step(); step();
    ticks = 0;
    for (int i = 0; i < 20 && ticks < 2; i++) begin
      step();
      if (((n - r0) % SC) == SC - 1) ticks++;
    end
    check("t6_not_yet", {31'd0, sw_out[3]}, 32'd0);
    rst = 1'b1; step(); rst = 1'b0;
    n0 = n + 1; found = 1'b0; lat = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (sw_out[3]) begin found = 1'b1; lat = n - n0; end
    end
    check("t6_sw3_rose", {31'd0, found}, 32'd1);
    check("t6_full_restart", lat, 32'd11);

    // random phase: bounces, long holds, clears, occasional reset
    for (int it = 0; it < 150; it++) begin
      hold    = $urandom_range(1, 18);
      bit_idx = $urandom_range(0, 3);
      sw_in[bit_idx] = ~sw_in[bit_idx];
      change_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      repeat (hold) step();
    end
    change_clr = 1'b0;
    repeat (40) step();
    check("queue_drained", evq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
